// File: rtl/buzzer_ctrl.sv
// Piezo buzzer driver: turns key-click / cook-done pulses into timed, toned beep patterns.
// Optional build macro BUZZER_MUTE_EN adds an i_mute input that silences o_buzz without disturbing timing.
module buzzer_ctrl #(
  parameter int unsigned TONE_HALF  = 25_000,
  parameter int unsigned CLICK_CYC  = 5_000_000,
  parameter int unsigned BEEP_CYC   = 30_000_000,
  parameter int unsigned GAP_CYC    = 20_000_000,
  parameter int unsigned DONE_BEEPS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_click,
  input  logic i_done,
  input  logic i_stop,
`ifdef BUZZER_MUTE_EN
  input  logic i_mute,
`endif
  output logic o_buzz,
  output logic o_busy
);

  localparam int unsigned MAX_A = (CLICK_CYC > BEEP_CYC) ? CLICK_CYC : BEEP_CYC;
  localparam int unsigned MAX_B = (MAX_A > GAP_CYC) ? MAX_A : GAP_CYC;
  localparam int unsigned MAX_C = (MAX_B > TONE_HALF) ? MAX_B : TONE_HALF;
  localparam int unsigned CW    = $clog2(MAX_C) + 1;

  localparam logic [CW-1:0] CLICK_LAST = CW'(CLICK_CYC - 1);
  localparam logic [CW-1:0] BEEP_LAST  = CW'(BEEP_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] TONE_LAST  = CW'(TONE_HALF - 1);
  localparam logic [3:0]    DONE_N     = 4'(DONE_BEEPS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BEEP = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam logic MODE_CLICK = 1'b0;
  localparam logic MODE_DONE  = 1'b1;

  logic [1:0]    state, state_nx;
  logic          mode, mode_nx;
  logic [CW-1:0] dur_cnt, dur_nx;
  logic [CW-1:0] tone_cnt, tone_nx;
  logic          tone_ph, ph_nx;
  logic [3:0]    beep_cnt, beep_nx;
  logic [3:0]    beep_inc;
  logic [CW-1:0] dur_last;
  logic          start, start_mode, go_idle;
  logic          buzz_nx;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign beep_inc = (beep_cnt == 4'hF) ? beep_cnt : beep_cnt + 4'd1;
  assign dur_last = (mode == MODE_CLICK) ? CLICK_LAST : BEEP_LAST;

  always_comb begin
    state_nx   = state;
    mode_nx    = mode;
    dur_nx     = dur_cnt;
    tone_nx    = tone_cnt;
    ph_nx      = tone_ph;
    beep_nx    = beep_cnt;
    start      = 1'b0;
    start_mode = MODE_CLICK;
    go_idle    = 1'b0;

    if (i_stop) begin
      go_idle = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (i_done) begin
            start      = 1'b1;
            start_mode = MODE_DONE;
          end else if (i_click) begin
            start      = 1'b1;
            start_mode = MODE_CLICK;
          end
        end
        BEEP: begin
          if (i_done) begin
            start      = 1'b1;
            start_mode = MODE_DONE;
          end else if (dur_cnt >= dur_last) begin
            // beep_inc includes the beep just finishing, so no trailing gap follows the last one
            if (mode == MODE_CLICK || beep_inc >= DONE_N) begin
              go_idle = 1'b1;
            end else begin
              state_nx = GAP;
              beep_nx  = beep_inc;
              dur_nx   = '0;
              tone_nx  = '0;
              ph_nx    = 1'b0;
            end
          end else begin
            dur_nx = sat_inc(dur_cnt);
            if (tone_cnt >= TONE_LAST) begin
              tone_nx = '0;
              ph_nx   = ~tone_ph;
            end else begin
              tone_nx = sat_inc(tone_cnt);
            end
          end
        end
        GAP: begin
          if (i_done) begin
            start      = 1'b1;
            start_mode = MODE_DONE;
          end else if (dur_cnt >= GAP_LAST) begin
            state_nx = BEEP;
            dur_nx   = '0;
            tone_nx  = '0;
            ph_nx    = 1'b1;
          end else begin
            dur_nx = sat_inc(dur_cnt);
          end
        end
        default: go_idle = 1'b1;
      endcase
    end

    // A new request always restarts its pattern from beep 1 with a fresh tone phase
    if (start) begin
      state_nx = BEEP;
      mode_nx  = start_mode;
      dur_nx   = '0;
      tone_nx  = '0;
      ph_nx    = 1'b1;
      beep_nx  = '0;
    end

    if (go_idle) begin
      state_nx = IDLE;
      mode_nx  = MODE_CLICK;
      dur_nx   = '0;
      tone_nx  = '0;
      ph_nx    = 1'b0;
      beep_nx  = '0;
    end

`ifdef BUZZER_MUTE_EN
    buzz_nx = (state_nx == BEEP) && ph_nx && !i_mute;
`else
    buzz_nx = (state_nx == BEEP) && ph_nx;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mode     <= MODE_CLICK;
      dur_cnt  <= '0;
      tone_cnt <= '0;
      tone_ph  <= 1'b0;
      beep_cnt <= '0;
      o_buzz   <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      state    <= state_nx;
      mode     <= mode_nx;
      dur_cnt  <= dur_nx;
      tone_cnt <= tone_nx;
      tone_ph  <= ph_nx;
      beep_cnt <= beep_nx;
      o_buzz   <= buzz_nx;
      o_busy   <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_buzzer_ctrl.sv
// Scoreboard bench for buzzer_ctrl: each scenario queues its per-cycle expected {busy,buzz}
// waveform, and a negedge monitor pops and compares one entry per clock.
module tb_buzzer_ctrl;

  localparam int unsigned TH = 4;
  localparam int unsigned CC = 16;
  localparam int unsigned BC = 32;
  localparam int unsigned GC = 16;
  localparam int unsigned NB = 3;

  logic clk = 1'b0;
  logic rst, i_click, i_done, i_stop;
`ifdef BUZZER_MUTE_EN
  logic i_mute;
`endif
  logic o_buzz, o_busy;

  typedef struct {
    string tag;
    logic  busy;
    logic  buzz;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int rises  = 0;
  logic buzz_prev = 1'b0;

  buzzer_ctrl #(
    .TONE_HALF (TH),
    .CLICK_CYC (CC),
    .BEEP_CYC  (BC),
    .GAP_CYC   (GC),
    .DONE_BEEPS(NB)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_click(i_click),
    .i_done (i_done),
    .i_stop (i_stop),
`ifdef BUZZER_MUTE_EN
    .i_mute (i_mute),
`endif
    .o_buzz (o_buzz),
    .o_busy (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check_eq(e.tag, {30'd0, o_busy, o_buzz}, {30'd0, e.busy, e.buzz});
    end
    if (o_buzz === 1'b1 && buzz_prev === 1'b0) rises <= rises + 1;
    buzz_prev <= o_buzz;
  end

  task automatic push(input string tag, input logic busy, input logic buzz);
    exp_t e;
    e.tag  = tag;
    e.busy = busy;
    e.buzz = buzz;
    sb.push_back(e);
  endtask

  task automatic push_idle(input string name, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) push($sformatf("%s_idle%0d", name, k), 1'b0, 1'b0);
  endtask

  // Click cycles 0..upto; tone starts high for TH cycles then alternates
  task automatic push_click(input string name, input int unsigned upto);
    for (int unsigned k = 0; k <= upto; k++)
      push($sformatf("%s_click%0d", name, k), 1'b1, ((k / TH) % 2) == 0);
  endtask

  // Done cycles 0..upto: beeps of BC start every BC+GC cycles, silence in between
  task automatic push_done(input string name, input int unsigned upto);
    for (int unsigned k = 0; k <= upto; k++) begin
      int unsigned pos;
      pos = k % (BC + GC);
      if (pos < BC) push($sformatf("%s_done%0d", name, k), 1'b1, ((pos / TH) % 2) == 0);
      else          push($sformatf("%s_done%0d", name, k), 1'b1, 1'b0);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int unsigned n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (sb.size() != 0 && n < 1000);
    #1;
    check_eq({name, "_drain"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    rst = 1'b1; i_click = 1'b1; i_done = 1'b0; i_stop = 1'b0;
`ifdef BUZZER_MUTE_EN
    i_mute = 1'b0;
`endif
    // Reset held for 3 edges with i_click asserted: outputs stay quiet
    tick(1);
    push_idle("rst", 3);
    tick(2);
    rst = 1'b0; i_click = 1'b0;
    wait_drain("rst");

    // Single click
    i_click = 1'b1;
    push("click_pre", 1'b0, 1'b0);
    push_click("click", CC - 1);
    push_idle("click", 2);
    tick(1);
    i_click = 1'b0;
    wait_drain("click");

    // Full done pattern plus rising-edge count
    r0 = rises;
    i_done = 1'b1;
    push("done_pre", 1'b0, 1'b0);
    push_done("done", 2 * GC + 3 * BC - 1);
    push_idle("done", 2);
    tick(1);
    i_done = 1'b0;
    wait_drain("done");
    check_eq("done_rises", 32'(rises - r0), 32'd12);

    // Simultaneous click+done picks done; a click at done cycle 50 is ignored
    i_click = 1'b1; i_done = 1'b1;
    push("both_pre", 1'b0, 1'b0);
    push_done("both", 2 * GC + 3 * BC - 1);
    push_idle("both", 2);
    tick(1);
    i_click = 1'b0; i_done = 1'b0;
    tick(50);
    i_click = 1'b1;
    tick(1);
    i_click = 1'b0;
    wait_drain("both");

    // Done at click cycle 5 aborts the click and starts the full done pattern
    i_click = 1'b1;
    push("abort_pre", 1'b0, 1'b0);
    push_click("abort", 5);
    push_done("abort", 2 * GC + 3 * BC - 1);
    push_idle("abort", 2);
    tick(1);
    i_click = 1'b0;
    tick(5);
    i_done = 1'b1;
    tick(1);
    i_done = 1'b0;
    wait_drain("abort");

    // Done restarted while a done pattern is running (cycle 60, inside beep 2)
    i_done = 1'b1;
    push("rstrt_pre", 1'b0, 1'b0);
    push_done("rstrt_a", 60);
    push_done("rstrt_b", 2 * GC + 3 * BC - 1);
    push_idle("rstrt", 2);
    tick(1);
    i_done = 1'b0;
    tick(60);
    i_done = 1'b1;
    tick(1);
    i_done = 1'b0;
    wait_drain("rstrt");

    // Stop in the first gap; requests while stop is held are ignored
    i_done = 1'b1;
    push("stop_pre", 1'b0, 1'b0);
    push_done("stop", 40);
    push_idle("stop", 6);
    tick(1);
    i_done = 1'b0;
    tick(40);
    i_stop = 1'b1;
    tick(1);
    i_click = 1'b1;
    tick(1);
    i_click = 1'b0; i_done = 1'b1;
    tick(1);
    i_done = 1'b0;
    tick(1);
    i_stop = 1'b0;
    wait_drain("stop");

    // Reset mid-pattern aborts at the next edge
    i_done = 1'b1;
    push("mrst_pre", 1'b0, 1'b0);
    push_done("mrst", 10);
    push_idle("mrst", 3);
    tick(1);
    i_done = 1'b0;
    tick(10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    wait_drain("mrst");

`ifdef BUZZER_MUTE_EN
    // Mute over click cycles 5..10; tone phase keeps running underneath
    i_click = 1'b1;
    push("mute_pre", 1'b0, 1'b0);
    for (int unsigned k = 0; k < CC; k++)
      push($sformatf("mute_click%0d", k), 1'b1,
           (k >= 5 && k <= 10) ? 1'b0 : (((k / TH) % 2) == 0));
    push_idle("mute", 2);
    tick(1);
    i_click = 1'b0;
    tick(4);
    i_mute = 1'b1;
    tick(6);
    i_mute = 1'b0;
    wait_drain("mute");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
